// File: rtl/wrf_arb2.sv
// wrf_arb2: two-input WR fabric frame arbiter.
// Shares one pipelined 16-bit fabric source between two fabric sinks with
// frame-granular round-robin grants, and counts forwarded frames per port.
module wrf_arb2 #(
  parameter string       g_interface_mode      = "PIPELINED",
  parameter string       g_address_granularity = "BYTE",
  parameter int unsigned g_cnt_width           = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_n_i,

  input  logic                   snk0_cyc_i,
  input  logic                   snk0_stb_i,
  input  logic                   snk0_we_i,
  input  logic [1:0]             snk0_sel_i,
  input  logic [1:0]             snk0_adr_i,
  input  logic [15:0]            snk0_dat_i,
  output logic                   snk0_ack_o,
  output logic                   snk0_stall_o,
  output logic                   snk0_err_o,

  input  logic                   snk1_cyc_i,
  input  logic                   snk1_stb_i,
  input  logic                   snk1_we_i,
  input  logic [1:0]             snk1_sel_i,
  input  logic [1:0]             snk1_adr_i,
  input  logic [15:0]            snk1_dat_i,
  output logic                   snk1_ack_o,
  output logic                   snk1_stall_o,
  output logic                   snk1_err_o,

  output logic                   src_cyc_o,
  output logic                   src_stb_o,
  output logic                   src_we_o,
  output logic [1:0]             src_sel_o,
  output logic [1:0]             src_adr_o,
  output logic [15:0]            src_dat_o,
  input  logic                   src_ack_i,
  input  logic                   src_stall_i,
  input  logic                   src_err_i,

  output logic [1:0]             grant_o,
  input  logic                   cnt_clr_i,
  output logic [g_cnt_width-1:0] frames0_o,
  output logic [g_cnt_width-1:0] frames1_o
);

  // Only the pipelined fabric flavour is implemented; granularity is not
  // interpreted here but must still name a valid fabric setting.
  if (g_interface_mode != "PIPELINED") begin : g_mode_check
    $error("wrf_arb2: only PIPELINED interface mode is supported");
  end
  if (g_address_granularity != "BYTE" && g_address_granularity != "WORD") begin : g_gran_check
    $error("wrf_arb2: address granularity must be BYTE or WORD");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam logic [g_cnt_width-1:0] c_cnt_one = {{(g_cnt_width-1){1'b0}}, 1'b1};

  state_t                 state_q;
  state_t                 state_d;
  logic                   last_q;
  logic                   last_d;
  logic [1:0]             grant_q;
  logic                   frame_done0;
  logic                   frame_done1;
  logic [g_cnt_width-1:0] frames0_q;
  logic [g_cnt_width-1:0] frames1_q;

  // Next grant: a grant is held until its own cyc drops, always passing
  // through IDLE, and contention is broken against the last granted port.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    frame_done0 = 1'b0;
    frame_done1 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (snk0_cyc_i && snk1_cyc_i) begin
          if (last_q) begin
            state_d = ST_GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_GNT1;
            last_d  = 1'b1;
          end
        end else if (snk0_cyc_i) begin
          state_d = ST_GNT0;
          last_d  = 1'b0;
        end else if (snk1_cyc_i) begin
          state_d = ST_GNT1;
          last_d  = 1'b1;
        end
      end
      ST_GNT0: begin
        if (!snk0_cyc_i) begin
          state_d     = ST_IDLE;
          frame_done0 = 1'b1;
        end
      end
      ST_GNT1: begin
        if (!snk1_cyc_i) begin
          state_d     = ST_IDLE;
          frame_done1 = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grant state, round-robin memory and the registered one-hot grant; last
  // resets to port 1 so that port 0 wins the first contention.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= {state_d == ST_GNT1, state_d == ST_GNT0};
    end
  end

  // Port 0 frame counter; a clear overrides a coinciding frame completion.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frames0_q <= '0;
    end else if (cnt_clr_i) begin
      frames0_q <= '0;
    end else if (frame_done0) begin
      frames0_q <= frames0_q + c_cnt_one;
    end
  end

  // Port 1 frame counter, same rules as port 0.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frames1_q <= '0;
    end else if (cnt_clr_i) begin
      frames1_q <= '0;
    end else if (frame_done1) begin
      frames1_q <= frames1_q + c_cnt_one;
    end
  end

  // Zero-latency fabric mux: the granted port drives the source and sees the
  // downstream responses; everyone else is stalled and late acks/errs are dropped.
  always_comb begin
    src_cyc_o    = 1'b0;
    src_stb_o    = 1'b0;
    src_we_o     = 1'b0;
    src_sel_o    = 2'b00;
    src_adr_o    = 2'b00;
    src_dat_o    = 16'h0000;
    snk0_stall_o = 1'b1;
    snk0_ack_o   = 1'b0;
    snk0_err_o   = 1'b0;
    snk1_stall_o = 1'b1;
    snk1_ack_o   = 1'b0;
    snk1_err_o   = 1'b0;
    case (state_q)
      ST_GNT0: begin
        src_cyc_o    = snk0_cyc_i;
        src_stb_o    = snk0_stb_i;
        src_we_o     = snk0_we_i;
        src_sel_o    = snk0_sel_i;
        src_adr_o    = snk0_adr_i;
        src_dat_o    = snk0_dat_i;
        snk0_stall_o = src_stall_i;
        snk0_ack_o   = src_ack_i & snk0_cyc_i;
        snk0_err_o   = src_err_i & snk0_cyc_i;
      end
      ST_GNT1: begin
        src_cyc_o    = snk1_cyc_i;
        src_stb_o    = snk1_stb_i;
        src_we_o     = snk1_we_i;
        src_sel_o    = snk1_sel_i;
        src_adr_o    = snk1_adr_i;
        src_dat_o    = snk1_dat_i;
        snk1_stall_o = src_stall_i;
        snk1_ack_o   = src_ack_i & snk1_cyc_i;
        snk1_err_o   = src_err_i & snk1_cyc_i;
      end
      default: begin
      end
    endcase
  end

  assign grant_o   = grant_q;
  assign frames0_o = frames0_q;
  assign frames1_o = frames1_q;

endmodule

// File: tb/tb_wrf_arb2.sv
// tb_wrf_arb2: scoreboard bench for the two-input fabric frame arbiter.
module tb_wrf_arb2;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic mCyc[2];
  logic mStb[2];
  logic mWe[2];
  logic [1:0] mSel[2];
  logic [1:0] mAdr[2];
  logic [15:0] mDat[2];
  logic snkAck[2];
  logic snkStall[2];
  logic snkErr[2];

  logic src_cyc, src_stb, src_we;
  logic [1:0] src_sel, src_adr;
  logic [15:0] src_dat;
  logic src_ack = 1'b0;
  logic src_stall = 1'b0;
  logic src_err = 1'b0;
  logic [1:0] grant;
  logic cnt_clr = 1'b0;
  logic [CW-1:0] frames0, frames1;

  int nChecks = 0;
  int nFails = 0;
  int srcWords = 0;
  bit chkGap = 1'b0;
  bit randStall = 1'b0;
  bit strayAck = 1'b0;

  logic [15:0] dataQ0[$];
  logic [15:0] dataQ1[$];
  int grantQ[$];

  wrf_arb2 #(
    .g_interface_mode("PIPELINED"),
    .g_address_granularity("BYTE"),
    .g_cnt_width(CW)
  ) dut (
    .clk_sys_i(clk),
    .rst_n_i(rst_n),
    .snk0_cyc_i(mCyc[0]),
    .snk0_stb_i(mStb[0]),
    .snk0_we_i(mWe[0]),
    .snk0_sel_i(mSel[0]),
    .snk0_adr_i(mAdr[0]),
    .snk0_dat_i(mDat[0]),
    .snk0_ack_o(snkAck[0]),
    .snk0_stall_o(snkStall[0]),
    .snk0_err_o(snkErr[0]),
    .snk1_cyc_i(mCyc[1]),
    .snk1_stb_i(mStb[1]),
    .snk1_we_i(mWe[1]),
    .snk1_sel_i(mSel[1]),
    .snk1_adr_i(mAdr[1]),
    .snk1_dat_i(mDat[1]),
    .snk1_ack_o(snkAck[1]),
    .snk1_stall_o(snkStall[1]),
    .snk1_err_o(snkErr[1]),
    .src_cyc_o(src_cyc),
    .src_stb_o(src_stb),
    .src_we_o(src_we),
    .src_sel_o(src_sel),
    .src_adr_o(src_adr),
    .src_dat_o(src_dat),
    .src_ack_i(src_ack),
    .src_stall_i(src_stall),
    .src_err_i(src_err),
    .grant_o(grant),
    .cnt_clr_i(cnt_clr),
    .frames0_o(frames0),
    .frames1_o(frames1)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pushWord(input int p, input logic [15:0] w);
    if (p == 0) dataQ0.push_back(w);
    else dataQ1.push_back(w);
  endtask

  // Everything a reset must leave on the outputs
  task automatic checkResetState();
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_frames0", 32'(frames0), 0);
    checkOutput("rst_frames1", 32'(frames1), 0);
    checkOutput("rst_src_cyc", 32'(src_cyc), 0);
    checkOutput("rst_src_stb", 32'(src_stb), 0);
    checkOutput("rst_src_dat", 32'(src_dat), 0);
    checkOutput("rst_stall0", 32'(snkStall[0]), 1);
    checkOutput("rst_stall1", 32'(snkStall[1]), 1);
    checkOutput("rst_ack0", 32'(snkAck[0]), 0);
    checkOutput("rst_ack1", 32'(snkAck[1]), 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pipelined fabric master on port p: one frame of nWords random words,
  // cyc held until all acks return; aborts quietly if reset hits mid-frame.
  task automatic applyStimulus(input int p, input int nWords, input bit chkLat, input bit clrAtEnd);
    int sent, acked, cycles;
    bit accepted;
    logic [15:0] w;
    sent = 0;
    acked = 0;
    cycles = 0;
    @(posedge clk);
    #1;
    w = 16'($urandom);
    mCyc[p] = 1'b1;
    mStb[p] = 1'b1;
    mWe[p] = 1'b1;
    mSel[p] = 2'b11;
    mAdr[p] = 2'(p + 1);
    mDat[p] = w;
    pushWord(p, w);
    while (acked < nWords && cycles < 1000 && rst_n) begin
      @(negedge clk);
      if (chkLat && cycles == 0) begin
        checkOutput("lat_src_cyc_before_grant", 32'(src_cyc), 0);
        checkOutput("lat_stall_before_grant", 32'(snkStall[p]), 1);
      end
      if (chkLat && cycles == 1) checkOutput("lat_src_cyc_granted", 32'(src_cyc), 1);
      if (snkAck[p]) acked++;
      accepted = mStb[p] && !snkStall[p];
      @(posedge clk);
      #1;
      cycles++;
      if (accepted) begin
        sent++;
        if (sent < nWords) begin
          w = 16'($urandom);
          mDat[p] = w;
          pushWord(p, w);
        end else begin
          mStb[p] = 1'b0;
        end
      end
    end
    mCyc[p] = 1'b0;
    mStb[p] = 1'b0;
    if (rst_n) begin
      checkOutput("frame_acks", acked, nWords);
      if (clrAtEnd) begin
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
      end
    end
  endtask

  task automatic runFrames(input int p, input int nFrames, input int nWords);
    for (int i = 0; i < nFrames; i++) applyStimulus(p, nWords, 1'b0, 1'b0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Downstream slave: acks each accepted word one cycle later, optional random stall
  initial begin : slaveModel
    logic acc;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      acc = src_stb && !src_stall && rst_n;
      @(posedge clk);
      #1;
      src_ack = acc || strayAck;
      src_stall = randStall ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Source-side monitor: grant order, idle gap, response routing and scoreboard pops
  initial begin : monitor
    logic [1:0] prevGrant;
    int idleRun;
    bit haveFallen;
    int owner;
    prevGrant = 2'b00;
    idleRun = 0;
    haveFallen = 1'b0;
    owner = 0;
    forever begin
      @(negedge clk);
      if (!chkGap) haveFallen = 1'b0;
      if (rst_n) begin
        if (grant != 2'b00 && prevGrant == 2'b00) begin
          if (chkGap && haveFallen) checkOutput("idle_gap", idleRun, 1);
          if (grantQ.size() == 0) begin
            checkOutput("grant_queue", grantQ.size(), 1);
          end else begin
            owner = grantQ.pop_front();
            checkOutput("grant_order", 32'(grant), 1 << owner);
          end
        end
        if (grant == 2'b00 && prevGrant != 2'b00) haveFallen = 1'b1;
        if (grant == 2'b00) begin
          idleRun++;
          checkOutput("idle_src_cyc", 32'(src_cyc), 0);
          checkOutput("idle_stall0", 32'(snkStall[0]), 1);
          checkOutput("idle_stall1", 32'(snkStall[1]), 1);
          checkOutput("idle_ack0", 32'(snkAck[0]), 0);
          checkOutput("idle_ack1", 32'(snkAck[1]), 0);
        end else begin
          idleRun = 0;
        end
        if (grant == 2'b01) begin
          checkOutput("g0_src_cyc", 32'(src_cyc), 32'(mCyc[0]));
          checkOutput("g0_stall0", 32'(snkStall[0]), 32'(src_stall));
          checkOutput("g0_stall1", 32'(snkStall[1]), 1);
          checkOutput("g0_ack0", 32'(snkAck[0]), 32'(src_ack && mCyc[0]));
        end
        if (grant == 2'b10) begin
          checkOutput("g1_src_cyc", 32'(src_cyc), 32'(mCyc[1]));
          checkOutput("g1_stall1", 32'(snkStall[1]), 32'(src_stall));
          checkOutput("g1_stall0", 32'(snkStall[0]), 1);
          checkOutput("g1_ack1", 32'(snkAck[1]), 32'(src_ack && mCyc[1]));
        end
        if (src_stb && !src_stall) begin
          srcWords++;
          checkOutput("src_adr", 32'(src_adr), owner + 1);
          if (owner == 0) begin
            if (dataQ0.size() == 0) checkOutput("data0_queue", dataQ0.size(), 1);
            else checkOutput("data0", 32'(src_dat), 32'(dataQ0.pop_front()));
          end else begin
            if (dataQ1.size() == 0) checkOutput("data1_queue", dataQ1.size(), 1);
            else checkOutput("data1", 32'(src_dat), 32'(dataQ1.pop_front()));
          end
        end
      end
      prevGrant = grant;
    end
  end

  // Watchdog so the run always ends
  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int target;
    for (int p = 0; p < 2; p++) begin
      mCyc[p] = 1'b0;
      mStb[p] = 1'b0;
      mWe[p] = 1'b0;
      mSel[p] = 2'b00;
      mAdr[p] = 2'b00;
      mDat[p] = 16'h0000;
    end

    $display("[TB] reset state");
    doReset();

    $display("[TB] single port 0 frame of 30 words");
    grantQ.push_back(0);
    applyStimulus(0, 30, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("single_frames0", 32'(frames0), 1);
    checkOutput("single_frames1", 32'(frames1), 0);

    $display("[TB] simultaneous request after reset");
    doReset();
    chkGap = 1'b1;
    grantQ.push_back(0);
    grantQ.push_back(1);
    fork
      applyStimulus(0, 8, 1'b0, 1'b0);
      applyStimulus(1, 8, 1'b0, 1'b0);
    join
    waitCycles(2);
    chkGap = 1'b0;
    checkOutput("simul_frames0", 32'(frames0), 1);
    checkOutput("simul_frames1", 32'(frames1), 1);

    $display("[TB] counter clear and round robin");
    cnt_clr = 1'b1;
    waitCycles(1);
    cnt_clr = 1'b0;
    checkOutput("clr_frames0", 32'(frames0), 0);
    checkOutput("clr_frames1", 32'(frames1), 0);
    chkGap = 1'b1;
    for (int i = 0; i < 6; i++) grantQ.push_back(i % 2);
    fork
      runFrames(0, 3, 4);
      runFrames(1, 3, 4);
    join
    waitCycles(2);
    chkGap = 1'b0;
    checkOutput("rr_frames0", 32'(frames0), 3);
    checkOutput("rr_frames1", 32'(frames1), 3);

    $display("[TB] stray ack while idle");
    strayAck = 1'b1;
    waitCycles(3);
    strayAck = 1'b0;
    waitCycles(1);

    $display("[TB] backpressure on port 1");
    randStall = 1'b1;
    grantQ.push_back(1);
    applyStimulus(1, 20, 1'b0, 1'b0);
    randStall = 1'b0;
    waitCycles(2);
    checkOutput("bp_frames1", 32'(frames1), 4);

    $display("[TB] counter wrap and clear collision");
    cnt_clr = 1'b1;
    waitCycles(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      grantQ.push_back(0);
      applyStimulus(0, 1, 1'b0, 1'b0);
    end
    waitCycles(2);
    checkOutput("wrap_preload", 32'(frames0), 15);
    grantQ.push_back(0);
    applyStimulus(0, 1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("wrap_to_zero", 32'(frames0), 0);
    grantQ.push_back(0);
    applyStimulus(0, 1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("wrap_plus_one", 32'(frames0), 1);
    grantQ.push_back(0);
    applyStimulus(0, 1, 1'b0, 1'b1);
    waitCycles(1);
    checkOutput("clr_beats_inc", 32'(frames0), 0);

    $display("[TB] reset in the middle of a port 1 frame");
    grantQ.push_back(1);
    target = srcWords + 10;
    fork
      applyStimulus(1, 20, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 500 && srcWords < target; i++) @(negedge clk);
        checkOutput("word10_reached", 32'(srcWords >= target), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_src_cyc", 32'(src_cyc), 0);
        checkOutput("midrst_grant", 32'(grant), 0);
        checkOutput("midrst_frames1", 32'(frames1), 0);
        checkOutput("midrst_stall1", 32'(snkStall[1]), 1);
      end
    join
    dataQ0.delete();
    dataQ1.delete();
    grantQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    grantQ.push_back(1);
    applyStimulus(1, 5, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("post_rst_frames1", 32'(frames1), 1);
    checkOutput("post_rst_frames0", 32'(frames0), 0);

    checkOutput("left_data0", dataQ0.size(), 0);
    checkOutput("left_data1", dataQ1.size(), 0);
    checkOutput("left_grants", grantQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
